// File: rtl/seq_mag_compare.sv
// Bit-serial, MSB-first magnitude comparator with a start/done handshake.
// One operand bit is examined per cycle, and the scan stops at the first differing bit.
module seq_mag_compare #(
  parameter int WIDTH     = 8,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic [2:0]       mode,
  input  logic             signed_cmp,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             lt,
  output logic             gt,
  output logic             result,
  output logic [1:0]       state_dbg
);

  // Handshake: start is sampled only in IDLE; the rising edge that sees it captures
  // x, y, mode and signed_cmp. done pulses for one cycle together with a fresh result.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int             IW      = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0]  MSB_IDX = IW'(WIDTH - 1);

  state_t           state, state_n;
  logic [IW-1:0]    idx, idx_n;
  logic [WIDTH-1:0] xr, xr_n, yr, yr_n;
  logic [2:0]       mode_r, mode_n;
  logic             sgn_r, sgn_n;
  logic             done_r, done_n;
  logic             eq_r, eq_n, lt_r, lt_n, gt_r, gt_n, res_r, res_n;
  logic             bit_x, bit_y, gt_bit;

  function automatic logic relation(input logic [2:0] m, input logic e,
                                    input logic l, input logic g);
    logic r;
    case (m)
      3'b000:  r = e;
      3'b001:  r = ~e;
      3'b010:  r = l;
      3'b011:  r = l | e;
      3'b100:  r = g;
      3'b101:  r = g | e;
      default: r = 1'b0;
    endcase
    return r;
  endfunction

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state  <= IDLE;
      idx    <= '0;
      xr     <= '0;
      yr     <= '0;
      mode_r <= '0;
      sgn_r  <= 1'b0;
      done_r <= 1'b0;
      eq_r   <= 1'b0;
      lt_r   <= 1'b0;
      gt_r   <= 1'b0;
      res_r  <= 1'b0;
    end else begin
      state  <= state_n;
      idx    <= idx_n;
      xr     <= xr_n;
      yr     <= yr_n;
      mode_r <= mode_n;
      sgn_r  <= sgn_n;
      done_r <= done_n;
      eq_r   <= eq_n;
      lt_r   <= lt_n;
      gt_r   <= gt_n;
      res_r  <= res_n;
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    xr_n    = xr;
    yr_n    = yr;
    mode_n  = mode_r;
    sgn_n   = sgn_r;
    done_n  = 1'b0;
    eq_n    = eq_r;
    lt_n    = lt_r;
    gt_n    = gt_r;
    res_n   = res_r;
    bit_x   = xr[idx];
    bit_y   = yr[idx];
    // A two's-complement sign bit weighs negative, so its sense flips at the MSB.
    gt_bit  = (sgn_r && (idx == MSB_IDX)) ? (~bit_x & bit_y) : (bit_x & ~bit_y);

    case (state)
      IDLE: begin
        if (start) begin
          xr_n    = x;
          yr_n    = y;
          mode_n  = mode;
          sgn_n   = signed_cmp & SIGNED_EN;
          idx_n   = MSB_IDX;
          state_n = SCAN;
        end
      end
      SCAN: begin
        if (bit_x != bit_y) begin
          eq_n    = 1'b0;
          gt_n    = gt_bit;
          lt_n    = ~gt_bit;
          res_n   = relation(mode_r, 1'b0, ~gt_bit, gt_bit);
          done_n  = 1'b1;
          state_n = DONE;
        end else if (idx == '0) begin
          eq_n    = 1'b1;
          gt_n    = 1'b0;
          lt_n    = 1'b0;
          res_n   = relation(mode_r, 1'b1, 1'b0, 1'b0);
          done_n  = 1'b1;
          state_n = DONE;
        end else begin
          idx_n = idx - IW'(1);
        end
      end
      DONE: state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  assign busy      = (state != IDLE);
  assign done      = done_r;
  assign eq        = eq_r;
  assign lt        = lt_r;
  assign gt        = gt_r;
  assign result    = res_r;
  assign state_dbg = state;

endmodule

// File: tb/tb_seq_mag_compare.sv
// Self-checking bench for seq_mag_compare: a signed-capable instance plus an
// unsigned-only instance, checked against a behavioural model through an expected queue.
module tb_seq_mag_compare;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         resetn = 1'b0;
  logic         start = 1'b0;
  logic [W-1:0] x = '0;
  logic [W-1:0] y = '0;
  logic [2:0]   mode = '0;
  logic         signed_cmp = 1'b0;

  logic busy_a, done_a, eq_a, lt_a, gt_a, result_a;
  logic busy_b, done_b, eq_b, lt_b, gt_b, result_b;
  logic [1:0] state_a, state_b;

  int checks = 0;
  int failures = 0;
  int done_cnt = 0;
  logic [3:0] exp_q[$];
  int         exp_k_q[$];
  logic [3:0] exp_b_q[$];

  seq_mag_compare #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_a (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y), .mode(mode),
    .signed_cmp(signed_cmp), .busy(busy_a), .done(done_a), .eq(eq_a), .lt(lt_a),
    .gt(gt_a), .result(result_a), .state_dbg(state_a));

  seq_mag_compare #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_b (
    .clk(clk), .resetn(resetn), .start(start), .x(x), .y(y), .mode(mode),
    .signed_cmp(signed_cmp), .busy(busy_b), .done(done_b), .eq(eq_b), .lt(lt_b),
    .gt(gt_b), .result(result_b), .state_dbg(state_b));

  always #5 clk = ~clk;

  always @(negedge clk) if (done_a) done_cnt++;

  function automatic logic [3:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                       input logic [2:0] m, input logic s);
    logic e, l, g, r;
    e = (a == b);
    if (s) begin
      l = ($signed(a) < $signed(b));
      g = ($signed(a) > $signed(b));
    end else begin
      l = (a < b);
      g = (a > b);
    end
    case (m)
      3'd0: r = e;
      3'd1: r = !e;
      3'd2: r = l;
      3'd3: r = l || e;
      3'd4: r = g;
      3'd5: r = g || e;
      default: r = 1'b0;
    endcase
    return {e, l, g, r};
  endfunction

  function automatic int lead_k(input logic [W-1:0] a, input logic [W-1:0] b);
    for (int i = W - 1; i >= 0; i--) if (a[i] != b[i]) return W - i;
    return W;
  endfunction

  // Drives one start pulse; returns half a cycle after the accepting edge E0.
  task automatic drive_start(input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [2:0] m, input logic s);
    @(negedge clk);
    x = a; y = b; mode = m; signed_cmp = s; start = 1'b1;
    exp_q.push_back(model(a, b, m, s));
    exp_k_q.push_back(lead_k(a, b));
    @(negedge clk);
    start = 1'b0;
  endtask

  // Waits (bounded) for done; k is the edge offset from E0, busy_lo counts idle cycles seen.
  task automatic wait_done(output int k, output bit ok, output int busy_lo);
    k = 0; ok = 1'b0; busy_lo = 0;
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge clk);
      if (!busy_a) busy_lo++;
      if (done_a) begin
        k = c; ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    #2;
    checks++;
    if ({busy_a, done_a, eq_a, lt_a, gt_a, result_a, state_a} !== 8'h00) begin
      failures++;
      $display("FAIL reset_outputs got=%b exp=00000000",
               {busy_a, done_a, eq_a, lt_a, gt_a, result_a, state_a});
    end
    repeat (2) @(negedge clk);
    resetn = 1'b1;
  endtask

  // Equal operands scan all bits: busy through E0..E0+8, done at E0+8.
  task automatic test_equal_full_scan();
    int k, bl, ek; bit ok; logic [3:0] e;
    drive_start(8'hA5, 8'hA5, 3'd5, 1'b0);
    checks++;
    if (busy_a !== 1'b1 || state_a !== 2'd1) begin
      failures++;
      $display("FAIL busy_after_accept got=%b/%0d exp=1/1", busy_a, state_a);
    end
    wait_done(k, ok, bl);
    e = exp_q.pop_front(); ek = exp_k_q.pop_front();
    checks++;
    if (!ok || k != ek || bl != 0) begin
      failures++;
      $display("FAIL equal_latency got=k%0d busy_lo%0d exp=k%0d busy_lo0", k, bl, ek);
    end
    checks++;
    if ({eq_a, lt_a, gt_a, result_a} !== e) begin
      failures++;
      $display("FAIL equal_result got=%b exp=%b", {eq_a, lt_a, gt_a, result_a}, e);
    end
    @(negedge clk);
    checks++;
    if (done_a !== 1'b0 || busy_a !== 1'b0) begin
      failures++;
      $display("FAIL done_one_cycle got=done%b busy%b exp=done0 busy0", done_a, busy_a);
    end
  endtask

  // MSB differs: single-cycle scan; signed reverses the verdict.
  task automatic test_msb_signed();
    int k, bl, ek; bit ok; logic [3:0] e;
    for (int s = 0; s < 2; s++) begin
      drive_start(8'h80, 8'h7F, 3'd4, s[0]);
      wait_done(k, ok, bl);
      e = exp_q.pop_front(); ek = exp_k_q.pop_front();
      checks++;
      if (!ok || k != ek) begin
        failures++;
        $display("FAIL msb_latency signed=%0d got=%0d exp=%0d", s, k, ek);
      end
      checks++;
      if ({eq_a, lt_a, gt_a, result_a} !== e) begin
        failures++;
        $display("FAIL msb_result signed=%0d got=%b exp=%b", s, {eq_a, lt_a, gt_a, result_a}, e);
      end
    end
  endtask

  // Starts issued during SCAN must be ignored and not queued.
  task automatic test_start_ignored();
    int first, cnt0, ek; logic [3:0] e;
    drive_start(8'h3C, 8'h38, 3'd3, 1'b0);
    x = 8'h00; y = 8'h00; start = 1'b1;
    cnt0 = done_cnt; first = 0;
    for (int c = 1; c <= 12; c++) begin
      @(negedge clk);
      if (c == 2) start = 1'b0;
      if (done_a && first == 0) begin
        first = c;
        e = exp_q.pop_front(); ek = exp_k_q.pop_front();
        checks++;
        if ({eq_a, lt_a, gt_a, result_a} !== e) begin
          failures++;
          $display("FAIL ignored_start_result got=%b exp=%b", {eq_a, lt_a, gt_a, result_a}, e);
        end
      end
    end
    checks++;
    if (first != 6 || done_cnt - cnt0 != 1) begin
      failures++;
      $display("FAIL ignored_start_done got=at%0d count%0d exp=at6 count1", first, done_cnt - cnt0);
    end
  endtask

  // Asynchronous reset mid-scan clears everything at once and suppresses done.
  task automatic test_async_reset();
    int k, bl, ek, cnt0; bit ok; logic [3:0] e;
    drive_start(8'h01, 8'h00, 3'd4, 1'b0);
    void'(exp_q.pop_front()); void'(exp_k_q.pop_front());
    cnt0 = done_cnt;
    repeat (3) @(posedge clk);
    #2 resetn = 1'b0;
    #1;
    checks++;
    if ({busy_a, done_a, eq_a, lt_a, gt_a, result_a, state_a} !== 8'h00) begin
      failures++;
      $display("FAIL async_reset_clear got=%b exp=00000000",
               {busy_a, done_a, eq_a, lt_a, gt_a, result_a, state_a});
    end
    repeat (10) @(negedge clk);
    checks++;
    if (done_cnt != cnt0) begin
      failures++;
      $display("FAIL aborted_no_done got=%0d exp=0", done_cnt - cnt0);
    end
    resetn = 1'b1;
    drive_start(8'h01, 8'h00, 3'd4, 1'b0);
    wait_done(k, ok, bl);
    e = exp_q.pop_front(); ek = exp_k_q.pop_front();
    checks++;
    if (!ok || k != ek || {eq_a, lt_a, gt_a, result_a} !== e) begin
      failures++;
      $display("FAIL post_reset_compare got=k%0d %b exp=k%0d %b", k, {eq_a, lt_a, gt_a, result_a}, ek, e);
    end
  endtask

  // Reserved mode and NE behaviour.
  task automatic test_modes();
    logic [W-1:0] xa[3] = '{8'h12, 8'h12, 8'h13};
    logic [2:0]   ma[3] = '{3'b110, 3'b001, 3'b001};
    int k, bl, ek; bit ok; logic [3:0] e;
    for (int i = 0; i < 3; i++) begin
      drive_start(xa[i], 8'h12, ma[i], 1'b0);
      wait_done(k, ok, bl);
      e = exp_q.pop_front(); ek = exp_k_q.pop_front();
      checks++;
      if (!ok || k != ek || {eq_a, lt_a, gt_a, result_a} !== e) begin
        failures++;
        $display("FAIL mode_case%0d got=k%0d %b exp=k%0d %b", i, k, {eq_a, lt_a, gt_a, result_a}, ek, e);
      end
    end
  endtask

  // Unsigned-only instance ignores signed_cmp; signed instance honours it.
  task automatic test_signed_disabled();
    int k, bl, ek; bit ok; logic [3:0] e, eb;
    exp_b_q.push_back(model(8'hFF, 8'h01, 3'd4, 1'b0));
    drive_start(8'hFF, 8'h01, 3'd4, 1'b1);
    wait_done(k, ok, bl);
    e = exp_q.pop_front(); ek = exp_k_q.pop_front(); eb = exp_b_q.pop_front();
    checks++;
    if (!ok || done_b !== 1'b1 || {eq_b, lt_b, gt_b, result_b} !== eb) begin
      failures++;
      $display("FAIL signed_disabled got=done%b %b exp=done1 %b", done_b, {eq_b, lt_b, gt_b, result_b}, eb);
    end
    checks++;
    if ({eq_a, lt_a, gt_a, result_a} !== e) begin
      failures++;
      $display("FAIL signed_enabled got=%b exp=%b", {eq_a, lt_a, gt_a, result_a}, e);
    end
  endtask

  // start held high: each new compare is accepted two cycles after the previous done.
  task automatic test_back_to_back();
    logic [W-1:0] a, b; logic [2:0] m; logic s;
    int cnt, ek; logic [3:0] e; bit seen;
    @(negedge clk);
    for (int n = 0; n < 8; n++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 3) == 0) ? a : (a ^ W'(1 << $urandom_range(0, W - 1)));
      m = 3'($urandom_range(0, 7)); s = 1'($urandom_range(0, 1));
      x = a; y = b; mode = m; signed_cmp = s; start = 1'b1;
      exp_q.push_back(model(a, b, m, s));
      exp_k_q.push_back(lead_k(a, b));
      seen = 1'b0; cnt = 0;
      for (int c = 1; c <= W + 4; c++) begin
        @(negedge clk);
        if (done_a) begin
          cnt = c; seen = 1'b1;
          break;
        end
      end
      e = exp_q.pop_front(); ek = exp_k_q.pop_front();
      checks++;
      if (!seen || cnt != ek + ((n == 0) ? 1 : 2) || {eq_a, lt_a, gt_a, result_a} !== e) begin
        failures++;
        $display("FAIL back_to_back%0d got=gap%0d %b exp=gap%0d %b", n, cnt,
                 {eq_a, lt_a, gt_a, result_a}, ek + ((n == 0) ? 1 : 2), e);
      end
    end
    start = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (busy_a !== 1'b0) begin
      failures++;
      $display("FAIL back_to_back_idle got=%b exp=0", busy_a);
    end
  endtask

  task automatic test_random();
    logic [W-1:0] a, b; int k, bl, ek; bit ok; logic [3:0] e;
    for (int n = 0; n < 20; n++) begin
      a = W'($urandom_range(0, 255));
      b = ($urandom_range(0, 4) == 0) ? a : (a ^ W'(1 << $urandom_range(0, W - 1)));
      drive_start(a, b, 3'($urandom_range(0, 7)), 1'($urandom_range(0, 1)));
      x = W'($urandom_range(0, 255)); y = W'($urandom_range(0, 255));
      wait_done(k, ok, bl);
      e = exp_q.pop_front(); ek = exp_k_q.pop_front();
      checks++;
      if (!ok || k != ek || {eq_a, lt_a, gt_a, result_a} !== e) begin
        failures++;
        $display("FAIL random%0d x=%h y=%h got=k%0d %b exp=k%0d %b", n, a, b, k,
                 {eq_a, lt_a, gt_a, result_a}, ek, e);
      end
    end
  endtask

  initial begin
    test_reset();
    test_equal_full_scan();
    test_msb_signed();
    test_start_ignored();
    test_async_reset();
    test_modes();
    test_signed_disabled();
    test_back_to_back();
    test_random();
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain got=%0d exp=0", exp_q.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
